// File: rtl/hud_digit_sequencer.sv
// hud_digit_sequencer
// One shared sequential engine converts the binary score and elapsed seconds
// into per-digit glyph base addresses in the font region of display memory.
// Score runs a 14-step double-dabble. Time runs a 14-step restoring divide
// by 60, then an 8-step parallel double-dabble of minutes and seconds.
// A digit group is written to its outputs in a single commit edge, so the
// display never shows a half-updated value.
module hud_digit_sequencer #(
    parameter logic [18:0] FONT_BASE  = 19'd307200,
    parameter logic [18:0] GLYPH_SIZE = 19'd525
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] score,
    input  logic [15:0] seconds,
    output logic [18:0] scoreAddr3,
    output logic [18:0] scoreAddr2,
    output logic [18:0] scoreAddr1,
    output logic [18:0] scoreAddr0,
    output logic [18:0] timeAddr3,
    output logic [18:0] timeAddr2,
    output logic [18:0] timeAddr1,
    output logic [18:0] timeAddr0,
    output logic        busy,
    output logic        done,
    output logic        doneTime
);

    typedef enum logic [2:0] {IDLE, SDAB, TDIV, TDAB, COMMIT} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [13:0] last_score, last_sec;
    logic        last_grant_time;
    logic [13:0] work;
    logic [19:0] sbcd;
    logic [5:0]  rem;
    logic [13:0] quo;
    logic [7:0]  min_bin, sec_bin, min_bcd, sec_bcd;

    logic        req_s, req_t, grant_s, grant_t;
    logic [19:0] sbcd_adj;
    logic [6:0]  trial, diff;
    logic        ge;
    logic [5:0]  rem_next;
    logic [13:0] quo_next;
    logic        sat;
    logic [7:0]  min_adj, sec_adj;
    logic        unused_bits;

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [18:0] glyph(input logic [3:0] d);
        return FONT_BASE + {15'd0, d} * GLYPH_SIZE;
    endfunction

    assign req_s = (score[13:0] != last_score);
    assign req_t = (seconds[13:0] != last_sec);
    assign busy  = (state != IDLE);

    assign sbcd_adj = {adj(sbcd[19:16]), adj(sbcd[15:12]), adj(sbcd[11:8]),
                       adj(sbcd[7:4]), adj(sbcd[3:0])};
    assign trial    = {rem, work[13]};
    assign diff     = trial - 7'd60;
    assign ge       = (trial >= 7'd60);
    assign rem_next = ge ? diff[5:0] : trial[5:0];
    assign quo_next = {quo[12:0], ge};
    assign sat      = (quo_next > 14'd99);
    assign min_adj  = {adj(min_bcd[7:4]), adj(min_bcd[3:0])};
    assign sec_adj  = {adj(sec_bcd[7:4]), adj(sec_bcd[3:0])};

    assign unused_bits = ^{score[31:14], seconds[15:14], sbcd_adj[19],
                           diff[6], quo[13], min_adj[7], sec_adj[7]};

    // Arbitration in IDLE: alternate on a tie, otherwise serve whoever asks
    always_comb begin
        grant_s = 1'b0;
        grant_t = 1'b0;
        if (state == IDLE) begin
            if (req_s && req_t) begin
                grant_s = last_grant_time;
                grant_t = !last_grant_time;
            end else begin
                grant_s = req_s;
                grant_t = req_t;
            end
        end
    end

    // Next-state sequencing through the conversion phases
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_s) state_next = SDAB;
                     else if (grant_t) state_next = TDIV;
            SDAB:    if (cnt == 4'd13) state_next = COMMIT;
            TDIV:    if (cnt == 4'd13) state_next = TDAB;
            TDAB:    if (cnt == 4'd7) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Conversion datapath: grant capture, dabble and divide steps
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt             <= 4'd0;
            last_score      <= 14'd0;
            last_sec        <= 14'd0;
            last_grant_time <= 1'b1;
            work            <= 14'd0;
            sbcd            <= 20'd0;
            rem             <= 6'd0;
            quo             <= 14'd0;
            min_bin         <= 8'd0;
            sec_bin         <= 8'd0;
            min_bcd         <= 8'd0;
            sec_bcd         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_s) begin
                        work            <= score[13:0];
                        last_score      <= score[13:0];
                        last_grant_time <= 1'b0;
                        sbcd            <= 20'd0;
                        cnt             <= 4'd0;
                    end else if (grant_t) begin
                        work            <= seconds[13:0];
                        last_sec        <= seconds[13:0];
                        last_grant_time <= 1'b1;
                        rem             <= 6'd0;
                        quo             <= 14'd0;
                        cnt             <= 4'd0;
                    end
                end
                SDAB: begin
                    sbcd <= {sbcd_adj[18:0], work[13]};
                    work <= {work[12:0], 1'b0};
                    cnt  <= cnt + 4'd1;
                end
                TDIV: begin
                    rem  <= rem_next;
                    quo  <= quo_next;
                    work <= {work[12:0], 1'b0};
                    if (cnt == 4'd13) begin
                        min_bin <= sat ? 8'd99 : quo_next[7:0];
                        sec_bin <= sat ? 8'd59 : {2'b00, rem_next};
                        min_bcd <= 8'd0;
                        sec_bcd <= 8'd0;
                        cnt     <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                TDAB: begin
                    min_bcd <= {min_adj[6:0], min_bin[7]};
                    sec_bcd <= {sec_adj[6:0], sec_bin[7]};
                    min_bin <= {min_bin[6:0], 1'b0};
                    sec_bin <= {sec_bin[6:0], 1'b0};
                    cnt     <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Atomic commit of the granted digit group plus the done pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            scoreAddr3 <= FONT_BASE;
            scoreAddr2 <= FONT_BASE;
            scoreAddr1 <= FONT_BASE;
            scoreAddr0 <= FONT_BASE;
            timeAddr3  <= FONT_BASE;
            timeAddr2  <= FONT_BASE;
            timeAddr1  <= FONT_BASE;
            timeAddr0  <= FONT_BASE;
            done       <= 1'b0;
            doneTime   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == COMMIT) begin
                done     <= 1'b1;
                doneTime <= last_grant_time;
                if (last_grant_time) begin
                    timeAddr3 <= glyph(min_bcd[7:4]);
                    timeAddr2 <= glyph(min_bcd[3:0]);
                    timeAddr1 <= glyph(sec_bcd[7:4]);
                    timeAddr0 <= glyph(sec_bcd[3:0]);
                end else begin
                    scoreAddr3 <= glyph(sbcd[15:12]);
                    scoreAddr2 <= glyph(sbcd[11:8]);
                    scoreAddr1 <= glyph(sbcd[7:4]);
                    scoreAddr0 <= glyph(sbcd[3:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_hud_digit_sequencer.sv
// tb_hud_digit_sequencer
// Directed scenarios plus random score/seconds changes, compared every cycle
// against a job-level reference model built from div/mod arithmetic and
// fixed job latencies.
module tb_hud_digit_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] score;
    logic [15:0] seconds;
    logic [18:0] scoreAddr3, scoreAddr2, scoreAddr1, scoreAddr0;
    logic [18:0] timeAddr3, timeAddr2, timeAddr1, timeAddr0;
    logic        busy, done, doneTime;

    int compare_count  = 0;
    int mismatch_count = 0;

    int m_last_score, m_last_sec;
    bit m_last_grant_time;
    int m_remaining;
    bit m_job_time;
    int m_job_val;
    bit m_done, m_done_time;
    int exp_s[4];
    int exp_t[4];

    hud_digit_sequencer dut (
        .clock     (clock),
        .resetn    (resetn),
        .score     (score),
        .seconds   (seconds),
        .scoreAddr3(scoreAddr3),
        .scoreAddr2(scoreAddr2),
        .scoreAddr1(scoreAddr1),
        .scoreAddr0(scoreAddr0),
        .timeAddr3 (timeAddr3),
        .timeAddr2 (timeAddr2),
        .timeAddr1 (timeAddr1),
        .timeAddr0 (timeAddr0),
        .busy      (busy),
        .done      (done),
        .doneTime  (doneTime)
    );

    // Free-running 100 MHz clock
    always #5 clock = ~clock;

    function automatic int glyph(input int d);
        return 307200 + d * 525;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compare_count++;
        if (observed != expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_last_score      = 0;
        m_last_sec        = 0;
        m_last_grant_time = 1'b1;
        m_remaining       = 0;
        m_done            = 1'b0;
        m_done_time       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_s[i] = 307200;
            exp_t[i] = 307200;
        end
    endtask

    task automatic modelCommit();
        int v, mins, secs;
        if (m_job_time) begin
            mins = m_job_val / 60;
            secs = m_job_val % 60;
            if (mins > 99) begin
                mins = 99;
                secs = 59;
            end
            exp_t[3] = glyph(mins / 10);
            exp_t[2] = glyph(mins % 10);
            exp_t[1] = glyph(secs / 10);
            exp_t[0] = glyph(secs % 10);
        end else begin
            v = m_job_val % 10000;
            exp_s[3] = glyph(v / 1000);
            exp_s[2] = glyph((v / 100) % 10);
            exp_s[1] = glyph((v / 10) % 10);
            exp_s[0] = glyph(v % 10);
        end
        m_done      = 1'b1;
        m_done_time = m_job_time;
    endtask

    // One rising edge of the reference model, using the inputs the DUT sampled
    task automatic modelEdge();
        int s14, t14;
        bit rs, rt, pick_time;
        if (!resetn) begin
            modelReset();
            return;
        end
        s14 = int'(score[13:0]);
        t14 = int'(seconds[13:0]);
        if (m_remaining > 0) begin
            m_remaining--;
            m_done = 1'b0;
            if (m_remaining == 0) modelCommit();
        end else begin
            m_done = 1'b0;
            rs = (s14 != m_last_score);
            rt = (t14 != m_last_sec);
            if (rs || rt) begin
                pick_time = (rs && rt) ? !m_last_grant_time : rt;
                m_job_time        = pick_time;
                m_last_grant_time = pick_time;
                if (pick_time) begin
                    m_job_val   = t14;
                    m_last_sec  = t14;
                    m_remaining = 23;
                end else begin
                    m_job_val    = s14;
                    m_last_score = s14;
                    m_remaining  = 15;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("busy", int'(busy), int'(m_remaining > 0));
        checkOutput("done", int'(done), int'(m_done));
        if (m_done) checkOutput("doneTime", int'(doneTime), int'(m_done_time));
        checkOutput("scoreAddr3", int'(scoreAddr3), exp_s[3]);
        checkOutput("scoreAddr2", int'(scoreAddr2), exp_s[2]);
        checkOutput("scoreAddr1", int'(scoreAddr1), exp_s[1]);
        checkOutput("scoreAddr0", int'(scoreAddr0), exp_s[0]);
        checkOutput("timeAddr3", int'(timeAddr3), exp_t[3]);
        checkOutput("timeAddr2", int'(timeAddr2), exp_t[2]);
        checkOutput("timeAddr1", int'(timeAddr1), exp_t[1]);
        checkOutput("timeAddr0", int'(timeAddr0), exp_t[0]);
    endtask

    task automatic runCycle();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkAll();
    endtask

    task automatic applyStimulus(input logic [31:0] new_score, input logic [15:0] new_sec,
                                 input int cycles);
        score   = new_score;
        seconds = new_sec;
        for (int i = 0; i < cycles; i++) runCycle();
    endtask

    // Main stimulus sequence
    initial begin
        resetn  = 1'b0;
        score   = 32'd0;
        seconds = 16'd0;
        modelReset();
        @(negedge clock);
        checkAll();
        @(negedge clock);
        resetn = 1'b1;

        $display("[TB] idle with constant zero inputs");
        applyStimulus(32'd0, 16'd0, 30);

        $display("[TB] score 1234");
        applyStimulus(32'd1234, 16'd0, 20);

        $display("[TB] seconds 754");
        applyStimulus(32'd1234, 16'd754, 30);

        $display("[TB] simultaneous score 16383 and seconds 6000");
        applyStimulus(32'd16383, 16'd6000, 50);

        $display("[TB] score 5 then 7 mid-conversion");
        applyStimulus(32'd5, 16'd6000, 5);
        applyStimulus(32'd7, 16'd6000, 40);

        $display("[TB] reset asserted mid-division");
        applyStimulus(32'd7, 16'd100, 6);
        resetn = 1'b0;
        #1;
        modelReset();
        checkAll();
        runCycle();
        resetn = 1'b1;
        applyStimulus(32'd7, 16'd100, 60);

        $display("[TB] random input changes");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) score = $urandom;
            if ($urandom_range(0, 29) == 0) seconds = 16'($urandom_range(0, 65535));
            runCycle();
        end
        applyStimulus(score, seconds, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
